// File: rtl/rng_pkg.sv
// Shared types and constants for the random-number arbitration controller.
// The polynomial constant documents which LFSR the controller is paired with.
package rng_pkg;

   typedef enum logic [1:0] {
      WARM  = 2'd0,
      READY = 2'd1,
      GAP   = 2'd2
   } rngState_e;

   localparam int          WARMUP_DEFAULT = 8;
   localparam logic [31:0] LFSR_POLY      = 32'h04C1_1DB7;

endpackage

// File: rtl/rng_rr_arb.sv
// Combinational round-robin picker.
// The search starts at ptr_i and wraps, so the lowest offset from the pointer wins.
module rng_rr_arb
   import rng_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PW-1:0]      ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PW-1:0]      idx_o,
   output logic               valid_o
);

   // Walk offsets from farthest to nearest so the nearest requester overwrites the rest.
   always_comb begin
      int            cand;
      logic [PW-1:0] candIdx;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      candIdx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = int'(ptr_i) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         candIdx = cand[PW-1:0];
         if (en_i && req_i[candIdx]) begin
            gnt_o          = '0;
            gnt_o[candIdx] = 1'b1;
            idx_o          = candIdx;
            valid_o        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rng_arb_ctrl.sv
// Shares one LFSR between NUM_REQ requesters: seeds it, discards warm-up words,
// then hands out one-cycle round-robin grants, each carrying a random word.
module rng_arb_ctrl
   import rng_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int WARMUP     = WARMUP_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  en_i,
   input  logic                  seed_wr_i,
   input  logic [DATA_WIDTH-1:0] seed_i,
   output logic                  lfsr_wr_o,
   output logic [DATA_WIDTH-1:0] lfsr_seed_o,
   input  logic [DATA_WIDTH-1:0] lfsr_dat_i,
   input  logic [NUM_REQ-1:0]    req_i,
   output logic [NUM_REQ-1:0]    gnt_o,
   output logic [DATA_WIDTH-1:0] dat_o,
   output logic                  ready_o
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(WARMUP + 1);

   rngState_e             state_q;
   logic [CW-1:0]         warmCnt_q;
   logic [PW-1:0]         ptr_q;
   logic [PW-1:0]         ptr_d;
   logic [NUM_REQ-1:0]    gnt_q;
   logic [DATA_WIDTH-1:0] dat_q;
   logic                  ready_q;
   logic                  lfsrWr_q;
   logic [DATA_WIDTH-1:0] lfsrSeed_q;

   logic [NUM_REQ-1:0]    arbGnt;
   logic [PW-1:0]         arbIdx;
   logic                  arbValid;

   rng_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) uArb (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .en_i    (en_i),
      .gnt_o   (arbGnt),
      .idx_o   (arbIdx),
      .valid_o (arbValid)
   );

   assign ptr_d = (arbIdx == PW'(NUM_REQ - 1)) ? '0 : arbIdx + PW'(1);

   // Reseed overrides everything; the load cycle itself is not counted as warm-up.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= WARM;
         warmCnt_q  <= '0;
         ptr_q      <= '0;
         gnt_q      <= '0;
         dat_q      <= '0;
         ready_q    <= 1'b0;
         lfsrWr_q   <= 1'b0;
         lfsrSeed_q <= '0;
      end else begin
         lfsrWr_q   <= seed_wr_i;
         lfsrSeed_q <= seed_wr_i ? seed_i : '0;
         gnt_q      <= '0;
         dat_q      <= '0;
         if (seed_wr_i) begin
            state_q   <= WARM;
            warmCnt_q <= '0;
            ready_q   <= 1'b0;
         end else begin
            case (state_q)
               WARM: begin
                  if (!lfsrWr_q) begin
                     if (warmCnt_q == CW'(WARMUP - 1)) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                     end else begin
                        warmCnt_q <= warmCnt_q + CW'(1);
                     end
                  end
               end
               READY: begin
                  if (arbValid) begin
                     gnt_q   <= arbGnt;
                     dat_q   <= lfsr_dat_i;
                     ptr_q   <= ptr_d;
                     state_q <= GAP;
                  end
               end
               GAP: begin
                  state_q <= READY;
               end
               default: begin
                  state_q <= WARM;
                  ready_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign lfsr_wr_o   = lfsrWr_q;
   assign lfsr_seed_o = lfsrSeed_q;
   assign gnt_o       = gnt_q;
   assign dat_o       = dat_q;
   assign ready_o     = ready_q;

endmodule
